// File: rtl/display_scheduler_pkg.sv
// display_sched_pkg
//  Shared types and constants for the dice / traffic-light display scheduler.
//  - state_t : scheduler state, 2-bit encoding fixed so it can be probed
//  - SEL_*   : values of the display mux select line
//  - max3    : helper used to size the dwell counter from the parameters
package display_sched_pkg;

    typedef enum logic [1:0] {
        SHOW_TL   = 2'd0,
        SHOW_DICE = 2'd1,
        ROLL      = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam logic SEL_DICE = 1'b0;
    localparam logic SEL_TL   = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// display_scheduler_if
//  Bundles the scheduler's user inputs and display-control outputs.
//  Ports (signals):
//   button   user button, asynchronous to clk (driven by master)
//   auto_en  enables the periodic auto switch to the dice view (driven by master)
//   sel      mux select, 0 = dice, 1 = traffic lights (driven by slave)
//   roll     dice roll line, dice rolls while high (driven by slave)
//   busy     high while rolling or holding the dice result (driven by slave)
interface display_scheduler_if;

    logic button;
    logic auto_en;
    logic sel;
    logic roll;
    logic busy;

    modport master (output button, output auto_en, input sel, input roll, input busy);
    modport slave  (input button, input auto_en, output sel, output roll, output busy);

endinterface

// File: rtl/display_scheduler_button_sync_edge.sv
// button_sync_edge
//  Brings the raw button into the clk domain and turns each rising edge into a
//  single-cycle pulse. A button held high produces exactly one pulse.
//  Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   async_in   raw button, asynchronous to clk
//   pulse_out  one-cycle request, registered
//  Latency: async_in high at edge k -> pulse_out high during the cycle after
//  edge k+2.
module button_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    logic [1:0] sync_reg;
    logic       hist_reg;
    logic       pulse_reg;

    // Two-stage synchroniser chain; stage 0 samples the raw input.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= (gi == 0) ? async_in : sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    // History flop plus registered edge detect keeps the pulse glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            hist_reg  <= sync_reg[1];
            pulse_reg <= sync_reg[1] & ~hist_reg;
        end
    end

    assign pulse_out = pulse_reg;

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler
//  Sequences the dice / traffic-light display mux. Traffic lights are the
//  default view; a button press rolls the dice and then holds the result on
//  the display. With auto_en set the view periodically flips to the dice
//  without rolling.
//  Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-low (0 = reset)
//   bus   display_scheduler_if.slave: button, auto_en in; sel, roll, busy out
//  Parameters:
//   TL_DWELL     cycles in SHOW_TL before an auto switch to SHOW_DICE
//   ROLL_CYCLES  cycles roll is held high
//   HOLD_CYCLES  cycles spent in HOLD and in SHOW_DICE
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int TL_DWELL    = 16,
    parameter int ROLL_CYCLES = 8,
    parameter int HOLD_CYCLES = 12
) (
    input  logic                clk,
    input  logic                rst,
    display_scheduler_if.slave  bus
);

    localparam int CNT_W = $clog2(max3(TL_DWELL, ROLL_CYCLES, HOLD_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] TL_LAST   = CNT_W'(TL_DWELL - 1);
    localparam logic [CNT_W-1:0] ROLL_LAST = CNT_W'(ROLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sel_reg, sel_next;
    logic             roll_reg, roll_next;
    logic             busy_reg, busy_next;
    logic             req;

    button_sync_edge u_button (
        .clk       (clk),
        .rst       (rst),
        .async_in  (bus.button),
        .pulse_out (req)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= SHOW_TL;
            cnt_reg   <= '0;
            sel_reg   <= SEL_TL;
            roll_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            roll_reg  <= roll_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;

        case (state_reg)
            SHOW_TL: begin
                if (req) begin
                    state_next = ROLL;
                end else if (!bus.auto_en) begin
                    // Without auto mode the dwell never starts counting.
                    cnt_next = '0;
                end else if (cnt_reg == TL_LAST) begin
                    state_next = SHOW_DICE;
                end
            end
            SHOW_DICE: begin
                if (req) begin
                    state_next = ROLL;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = SHOW_TL;
                end
            end
            ROLL: begin
                // Requests during a roll are dropped, not queued.
                if (cnt_reg == ROLL_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (req) begin
                    state_next = ROLL;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = SHOW_TL;
                end
            end
            default: begin
                state_next = SHOW_TL;
            end
        endcase

        // Every state entry (including HOLD -> ROLL re-roll) restarts the dwell.
        if (state_next != state_reg) begin
            cnt_next = '0;
        end

        // Outputs decode the next state so they switch on the same edge as it.
        sel_next  = (state_next == SHOW_TL) ? SEL_TL : SEL_DICE;
        roll_next = (state_next == ROLL);
        busy_next = (state_next == ROLL) || (state_next == HOLD);
    end

    assign bus.sel  = sel_reg;
    assign bus.roll = roll_reg;
    assign bus.busy = busy_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
//  Scoreboard bench: a timeline reference model runs on each rising edge and
//  queues the expected display outputs; a monitor on the falling edge pops and
//  compares. Directed scenarios are followed by a randomized phase.
module tb_display_scheduler;

    localparam int TL_DWELL    = 16;
    localparam int ROLL_CYCLES = 8;
    localparam int HOLD_CYCLES = 12;

    localparam int PH_TL   = 0;
    localparam int PH_DICE = 1;
    localparam int PH_ROLL = 2;
    localparam int PH_HOLD = 3;
    localparam int NEVER   = -1000;

    typedef struct packed {
        logic sel;
        logic roll;
        logic busy;
    } out_t;

    logic clk = 1'b0;
    logic rst;

    display_scheduler_if bus ();

    display_scheduler #(
        .TL_DWELL    (TL_DWELL),
        .ROLL_CYCLES (ROLL_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    out_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the display is described as absolute-time windows.
    // A roll started at edge t shows roll over edges [t, t+ROLL) and the held
    // result over [t+ROLL, t+ROLL+HOLD). An auto dice view is a window of
    // HOLD edges. Anything outside a window is the traffic-light view.
    int edge_no;
    int roll_until;
    int hold_until;
    int dice_until;
    int tl_ref;
    int prev_ph;
    int btn_prev;
    int pend[$];

    function automatic int phase_at(input int t);
        if (t < roll_until) return PH_ROLL;
        if (t < hold_until) return PH_HOLD;
        if (t < dice_until) return PH_DICE;
        return PH_TL;
    endfunction

    task automatic model_reset();
        edge_no    = 0;
        roll_until = NEVER;
        hold_until = NEVER;
        dice_until = NEVER;
        tl_ref     = 0;
        prev_ph    = PH_TL;
        btn_prev   = 0;
        pend.delete();
    endtask

    always @(posedge clk) begin : model_step
        int   cur;
        bit   req;
        out_t x;
        if (rst === 1'b1) begin
            edge_no = edge_no + 1;
            req = 1'b0;
            if (pend.size() > 0 && pend[0] == edge_no) begin
                req = 1'b1;
                void'(pend.pop_front());
            end
            // A press seen at edge k becomes a request acted on at edge k+3.
            if (bus.button === 1'b1 && btn_prev == 0) pend.push_back(edge_no + 3);
            btn_prev = (bus.button === 1'b1) ? 1 : 0;

            if (req && prev_ph != PH_ROLL) begin
                roll_until = edge_no + ROLL_CYCLES;
                hold_until = roll_until + HOLD_CYCLES;
                dice_until = NEVER;
            end else if (prev_ph == PH_TL) begin
                if (bus.auto_en !== 1'b1) tl_ref = edge_no;
                else if (edge_no - tl_ref == TL_DWELL) dice_until = edge_no + HOLD_CYCLES;
            end

            cur = phase_at(edge_no);
            if (cur == PH_TL && prev_ph != PH_TL) tl_ref = edge_no;
            prev_ph = cur;

            x.sel  = (cur == PH_TL);
            x.roll = (cur == PH_ROLL);
            x.busy = (cur == PH_ROLL) || (cur == PH_HOLD);
            sb.push_back(x);
        end
    end

    out_t last_seen = '0;
    int   roll_run  = 0;
    int   last_run  = 0;

    always @(negedge clk) begin : monitor
        out_t got;
        out_t want;
        got = {bus.sel, bus.roll, bus.busy};
        if (got.roll === 1'b1) begin
            roll_run = roll_run + 1;
        end else if (roll_run > 0) begin
            last_run = roll_run;
            roll_run = 0;
        end
        if (sb.size() > 0) begin
            want = sb.pop_front();
            n_checks = n_checks + 1;
            if (got !== want) begin
                n_fail = n_fail + 1;
                $display("FAIL outputs t=%0t got sel=%b roll=%b busy=%b required sel=%b roll=%b busy=%b",
                         $time, got.sel, got.roll, got.busy, want.sel, want.roll, want.busy);
            end
        end
        if (got !== last_seen) begin
            $display("t=%0t display sel=%b roll=%b busy=%b", $time, got.sel, got.roll, got.busy);
        end
        last_seen = got;
    end

    task automatic check_int(input string name, input int got, input int want);
        n_checks = n_checks + 1;
        if (got != want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    // Asserts reset mid-cycle, checks outputs clear without a clock edge,
    // then releases on a falling edge after n cycles.
    task automatic do_reset(input int n);
        #2;
        rst = 1'b0;
        #1;
        check_int("reset_sel",  int'(bus.sel === 1'b1),  1);
        check_int("reset_roll", int'(bus.roll === 1'b0), 1);
        check_int("reset_busy", int'(bus.busy === 1'b0), 1);
        sb.delete();
        model_reset();
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press(input int hold);
        bus.button = 1'b1;
        repeat (hold) @(negedge clk);
        bus.button = 1'b0;
    endtask

    initial begin
        bus.button  = 1'b0;
        bus.auto_en = 1'b0;
        rst         = 1'b1;
        model_reset();

        // Power-on reset with the button already high.
        bus.button = 1'b1;
        do_reset(3);
        bus.button = 1'b0;

        // Idle with auto mode off, then auto mode periodic flipping.
        repeat (200) @(negedge clk);
        bus.auto_en = 1'b1;
        repeat (70) @(negedge clk);
        bus.auto_en = 1'b0;
        repeat (15) @(negedge clk);

        // Single press: full roll then hold.
        press(2);
        repeat (30) @(negedge clk);
        check_int("roll_len_single", last_run, ROLL_CYCLES);

        // Second press during ROLL is dropped.
        press(1);
        repeat (4) @(negedge clk);
        press(1);
        repeat (30) @(negedge clk);
        check_int("roll_len_ignored", last_run, ROLL_CYCLES);

        // Press during HOLD restarts the roll.
        press(1);
        repeat (14) @(negedge clk);
        press(1);
        repeat (40) @(negedge clk);
        check_int("roll_len_reroll", last_run, ROLL_CYCLES);

        // Button held for 50 cycles gives one sequence.
        press(50);
        repeat (40) @(negedge clk);
        check_int("roll_len_held", last_run, ROLL_CYCLES);

        // Reset during the 4th roll cycle truncates the roll pulse.
        press(1);
        repeat (6) @(negedge clk);
        do_reset(3);
        check_int("roll_len_reset", last_run, 4);
        repeat (5) @(negedge clk);

        // Randomized traffic with occasional asynchronous resets.
        bus.auto_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 9) == 0) bus.button = ~bus.button;
            if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
            else @(negedge clk);
        end
        bus.button = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
